// File: rtl/seven_segment_scan_decoder.sv
// seven_segment_scan_decoder
// Receive side of a scanned, multiplexed seven-segment display. The
// active-low anodes and segment lines are sampled on every clock. A pair
// that has been held long enough is decoded into the register of the
// digit whose anode is low. The stability counter keeps scan transitions
// and ghosting from being captured.
//
// Commit timing: a pair applied before edge k is sampled at edge k
// (counter = 1). The counter reaches STABLE_CYCLES at edge
// k+STABLE_CYCLES-1, and the commit lands on edge k+STABLE_CYCLES.
// One commit is made per stable dwell, however long the dwell lasts.
module seven_segment_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [6:0]                seg,
  input  logic [NUM_DIGITS-1:0]     an,
  output logic [4*NUM_DIGITS-1:0]   digits,
  output logic [NUM_DIGITS-1:0]     digit_valid,
  output logic [NUM_DIGITS-1:0]     digit_blank,
  output logic                      update,
  output logic [2:0]                update_idx,
  output logic                      err
);

  localparam int         SW     = NUM_DIGITS + 7;
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
  localparam logic [6:0] BLANK  = 7'b1111111;

  // Map an active-low gfedcba pattern to {legal, hex code}.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1000000: r = {1'b1, 4'h0};
      7'b1111001: r = {1'b1, 4'h1};
      7'b0100100: r = {1'b1, 4'h2};
      7'b0110000: r = {1'b1, 4'h3};
      7'b0011001: r = {1'b1, 4'h4};
      7'b0010010: r = {1'b1, 4'h5};
      7'b0000010: r = {1'b1, 4'h6};
      7'b1111000: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0010000: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'hA};
      7'b0000011: r = {1'b1, 4'hB};
      7'b1000110: r = {1'b1, 4'hC};
      7'b0100001: r = {1'b1, 4'hD};
      7'b0000110: r = {1'b1, 4'hE};
      7'b0001110: r = {1'b1, 4'hF};
      default:    r = {1'b0, 4'h0};
    endcase
    return r;
  endfunction

  // Sample stage state.
  logic [SW-1:0] samp_q, samp_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          pend_q, pend_d;

  // Output registers.
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic                    update_q, update_d;
  logic [2:0]              idx_q, idx_d;
  logic                    err_q, err_d;

  // Classification of the held (qualified) pair.
  logic [NUM_DIGITS-1:0] an_s;
  logic [6:0]            seg_s;
  logic [3:0]            zero_cnt;
  logic [4:0]            dec;

  assign an_s  = samp_q[SW-1:7];
  assign seg_s = samp_q[6:0];
  assign dec   = decode_seg(seg_s);

  // Stability qualification; pend marks the edge where the count first saturates.
  always_comb begin
    samp_d = {an, seg};
    cnt_d  = cnt_q;
    pend_d = 1'b0;
    if (samp_d != samp_q) begin
      cnt_d = 8'd1;
    end else if (cnt_q != STABLE) begin
      cnt_d = cnt_q + 8'd1;
    end
    pend_d = (cnt_d == STABLE) && (cnt_q != STABLE);
  end

  // Count low anodes in the held pair; multi-hot outranks segment content.
  always_comb begin
    zero_cnt = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_s[i]) zero_cnt = zero_cnt + 4'd1;
    end
  end

  // Commit decode: update digit registers and generate the one-cycle pulses.
  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    blank_d  = blank_q;
    update_d = 1'b0;
    idx_d    = idx_q;
    err_d    = 1'b0;
    if (pend_q) begin
      if (zero_cnt > 4'd1) begin
        err_d = 1'b1;
      end else if (zero_cnt == 4'd1) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (!an_s[i]) begin
            update_d = 1'b1;
            idx_d    = 3'(i);
            if (dec[4]) begin
              digits_d[4*i +: 4] = dec[3:0];
              valid_d[i]         = 1'b1;
              blank_d[i]         = 1'b0;
            end else if (seg_s == BLANK) begin
              valid_d[i] = 1'b0;
              blank_d[i] = 1'b1;
            end else begin
              valid_d[i] = 1'b0;
              blank_d[i] = 1'b0;
              err_d      = 1'b1;
            end
          end
        end
      end
    end
  end

  // State register with asynchronous reset; reset drops any pending commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_q   <= '1;
      cnt_q    <= 8'd0;
      pend_q   <= 1'b0;
      digits_q <= '0;
      valid_q  <= '0;
      blank_q  <= '0;
      update_q <= 1'b0;
      idx_q    <= 3'd0;
      err_q    <= 1'b0;
    end else begin
      samp_q   <= samp_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      blank_q  <= blank_d;
      update_q <= update_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign digit_blank = blank_q;
  assign update      = update_q;
  assign update_idx  = idx_q;
  assign err         = err_q;

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// tb_seven_segment_scan_decoder
// Drives dwells of {an, seg} and predicts each commit with an independent
// table-lookup model. The model pushes the expected commit cycle and
// output state to exp_q. A negedge monitor pops an entry on every
// update/err pulse and compares it.
module tb_seven_segment_scan_decoder;

  localparam int ND = 4;
  localparam int S  = 4;
  localparam int W  = 48;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [6:0]      tb_seg = 7'h7f;
  logic [ND-1:0]   tb_an = '1;
  logic [4*ND-1:0] digits;
  logic [ND-1:0]   digit_valid;
  logic [ND-1:0]   digit_blank;
  logic            update;
  logic [2:0]      update_idx;
  logic            err;

  seven_segment_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg         (tb_seg),
    .an          (tb_an),
    .digits      (digits),
    .digit_valid (digit_valid),
    .digit_blank (digit_blank),
    .update      (update),
    .update_idx  (update_idx),
    .err         (err)
  );

  // Clock and edge counter.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model of the output registers.
  logic [4*ND-1:0] m_digits = '0;
  logic [ND-1:0]   m_valid  = '0;
  logic [ND-1:0]   m_blank  = '0;
  logic [2:0]      m_idx    = '0;

  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] pack(input int c, input logic e, input logic u);
    return {16'(c), 3'b0, e, u, m_idx, m_digits, m_valid, m_blank};
  endfunction

  // Driver: hold a pair for n cycles; predict a commit when n >= S.
  task automatic dwell(input logic [ND-1:0] a, input logic [6:0] s, input int n);
    int nz;
    int hi;
    int code;
    logic e;
    tb_an  = a;
    tb_seg = s;
    if (n >= S) begin
      nz = 0;
      hi = 0;
      for (int i = 0; i < ND; i++) begin
        if (!a[i]) begin
          nz++;
          hi = i;
        end
      end
      if (nz >= 2) begin
        exp_q.push_back(pack(cyc + 1 + S, 1'b1, 1'b0));
      end else if (nz == 1) begin
        code = -1;
        for (int c = 0; c < 16; c++) if (SEG_TAB[c] == s) code = c;
        m_idx = 3'(hi);
        e = 1'b0;
        if (code >= 0) begin
          m_digits[hi*4 +: 4] = 4'(code);
          m_valid[hi] = 1'b1;
          m_blank[hi] = 1'b0;
        end else if (s == 7'h7f) begin
          m_valid[hi] = 1'b0;
          m_blank[hi] = 1'b1;
        end else begin
          m_valid[hi] = 1'b0;
          m_blank[hi] = 1'b0;
          e = 1'b1;
        end
        exp_q.push_back(pack(cyc + 1 + S, e, 1'b1));
      end
    end
    repeat (n) @(negedge clk);
  endtask

  // Idle long enough for any pending commit to land, then require an empty queue.
  task automatic drain(input string tag);
    dwell('1, 7'h7f, S + 3);
    check_eq(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard monitor: every pulse must match the oldest prediction.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && (update || err)) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_pulse", {62'd0, update, err}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("commit_cycle", 64'(cyc[15:0]), 64'(e[47:32]));
        if (e[27])
          check_eq("commit_state", 64'({err, update, update_idx, digits, digit_valid, digit_blank}), 64'(e[28:0]));
        else
          check_eq("err_state", 64'({err, update, digits, digit_valid, digit_blank}), 64'({e[28:27], e[23:0]}));
      end
    end
  end

  initial begin
    // Reset with random inputs, release on idle anodes.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tb_an  = 4'($urandom_range(0, 15));
      tb_seg = 7'($urandom_range(0, 127));
      @(negedge clk);
    end
    tb_an  = '1;
    tb_seg = 7'($urandom_range(0, 127));
    rst    = 1'b0;
    check_eq("rst_digits", 64'(digits), 64'd0);
    check_eq("rst_flags", 64'({digit_valid, digit_blank, update, update_idx, err}), 64'd0);
    dwell('1, tb_seg, 20);
    check_eq("rst_idle_queue", 64'(exp_q.size()), 64'd0);

    // Single digit, pattern 2 on digit 1.
    dwell(4'b1101, SEG_TAB[2], 10);
    check_eq("single_digit1", 64'(digits[7:4]), 64'h2);

    // Full scan 0, 9, A, F.
    dwell(4'b1110, SEG_TAB[0],  8);
    dwell(4'b1101, SEG_TAB[9],  8);
    dwell(4'b1011, SEG_TAB[10], 8);
    dwell(4'b0111, SEG_TAB[15], 8);
    drain("scan_drain");
    check_eq("scan_digits", 64'(digits), 64'hFA90);
    check_eq("scan_valid", 64'(digit_valid), 64'hF);

    // Short dwell, then a dwell with a one-cycle glitch.
    dwell(4'b1110, SEG_TAB[7], 3);
    dwell('1, 7'h7f, 2);
    dwell(4'b1110, SEG_TAB[7], 4);
    dwell(4'b1110, 7'b1111010, 1);
    dwell(4'b1110, SEG_TAB[7], 5);
    drain("glitch_drain");
    check_eq("glitch_digit0", 64'(digits[3:0]), 64'h7);

    // Blank then illegal pattern on digit 2.
    dwell(4'b1011, 7'h7f, 6);
    check_eq("blank_flags", 64'({digit_valid[2], digit_blank[2]}), 64'b01);
    dwell(4'b1011, 7'b0111111, 6);
    drain("illegal_drain");
    check_eq("illegal_digit2", 64'(digits[11:8]), 64'hA);
    check_eq("illegal_blank2", 64'(digit_blank[2]), 64'd0);

    // Multi-hot anodes.
    dwell(4'b1100, SEG_TAB[5], 6);
    drain("multihot_drain");
    check_eq("multihot_digits", 64'(digits), 64'(m_digits));

    // Reset asserted with the counter at 3 of a legal dwell.
    tb_an  = 4'b1110;
    tb_seg = SEG_TAB[3];
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_digits", 64'(digits), 64'd0);
    check_eq("midrst_flags", 64'({digit_valid, digit_blank, update, update_idx, err}), 64'd0);
    m_digits = '0;
    m_valid  = '0;
    m_blank  = '0;
    m_idx    = '0;
    @(negedge clk);
    tb_an = '1;
    rst   = 1'b0;
    dwell('1, 7'h7f, 20);
    check_eq("midrst_after", 64'({digits, digit_valid}), 64'd0);
    check_eq("final_queue", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
